// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// - RF_AW / RF_DW / NREGS : register file geometry (32 x 32-bit)
// - WB_ALU / WB_LD / WB_MD : requester indices of the standard writeback sources
// - GIDW                   : width of the exported grant index
// - reg_onehot()           : register number to 32-bit one-hot mask
package regfile_wb_arbiter_pkg;

  localparam int NREGS = 32;
  localparam int RF_AW = 5;
  localparam int RF_DW = 32;
  localparam int GIDW  = 3;

  localparam int WB_ALU = 0;
  localparam int WB_LD  = 1;
  localparam int WB_MD  = 2;

  function automatic logic [NREGS-1:0] reg_onehot(input logic [RF_AW-1:0] r);
    logic [NREGS-1:0] oh;
    oh    = '0;
    oh[r] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// - req_i   : N request bits
// - ptr_i   : highest-priority index this cycle (must be < N)
// - gnt_o   : one-hot grant (zero when no request)
// - idx_o   : encoded index of the granted requester
// - valid_o : any request granted
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // Scan N positions starting at ptr_i, wrapping once; the first
  // requesting position wins.
  always_comb begin
    int c;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    c       = 0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr_i) + k;
      if (c >= N) c = c - N;
      if (!valid_o && req_i[c]) begin
        valid_o  = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single write port of the 32x32 register file between N
// writeback sources. Each source owns a one-entry slot; a round-robin
// arbiter drains one slot per cycle into the registered WE/Rw/busW.
// - CLK, RST_n          : clock, asynchronous active-low reset
// - req_valid/req_ready : per-requester handshake
// - req_rw, req_data    : per-requester destination / data (packed, i*W +: W)
// - WE, Rw, busW        : registered register-file write port
// - pend_mask           : registers with a write held in a slot or on WE
// - grant_id            : requester whose write is currently on WE/Rw/busW
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int N       = 3,
  parameter int DW      = RF_DW,
  parameter int AW      = RF_AW,
  parameter bit DROP_R0 = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [N*AW-1:0]   req_rw,
  input  logic [N*DW-1:0]   req_data,
  output logic              WE,
  output logic [AW-1:0]     Rw,
  output logic [DW-1:0]     busW,
  output logic [NREGS-1:0]  pend_mask,
  output logic [GIDW-1:0]   grant_id
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  slot_full_q, slot_full_d;
  logic [AW-1:0] slot_rw_q   [N];
  logic [AW-1:0] slot_rw_d   [N];
  logic [DW-1:0] slot_data_q [N];
  logic [DW-1:0] slot_data_d [N];

  logic            we_q, we_d;
  logic [AW-1:0]   rw_out_q, rw_out_d;
  logic [DW-1:0]   busw_q, busw_d;
  logic [GIDW-1:0] gid_q, gid_d;
  logic [IW-1:0]   ptr_q, ptr_d;

  logic [N-1:0]  gnt;
  logic [IW-1:0] win_idx;
  logic          any_gnt;

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .req_i   (slot_full_q),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .idx_o   (win_idx),
    .valid_o (any_gnt)
  );

  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    logic [AW-1:0] in_rw;
    logic [DW-1:0] in_data;
    logic          take;
    logic          drop;

    assign in_rw   = req_rw[gi*AW +: AW];
    assign in_data = req_data[gi*DW +: DW];

    // A slot being drained this cycle can take a new entry at the same edge.
    assign req_ready[gi] = ~slot_full_q[gi] | gnt[gi];
    assign take          = req_valid[gi] & req_ready[gi];
    assign drop          = DROP_R0 && (in_rw == '0);

    // Writes to r0 are consumed but never occupy the slot; a refill
    // takes precedence over the drain of the old entry.
    assign slot_full_d[gi] = take ? ~drop : (slot_full_q[gi] & ~gnt[gi]);
    assign slot_rw_d[gi]   = take ? in_rw   : slot_rw_q[gi];
    assign slot_data_d[gi] = take ? in_data : slot_data_q[gi];
  end

  // Output stage next state: load the winner, otherwise only WE drops.
  always_comb begin
    we_d     = any_gnt;
    rw_out_d = rw_out_q;
    busw_d   = busw_q;
    gid_d    = gid_q;
    ptr_d    = ptr_q;
    if (any_gnt) begin
      rw_out_d = slot_rw_q[win_idx];
      busw_d   = slot_data_q[win_idx];
      gid_d    = GIDW'(win_idx);
      ptr_d    = (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      slot_full_q <= '0;
      slot_rw_q   <= '{default: '0};
      slot_data_q <= '{default: '0};
      we_q        <= 1'b0;
      rw_out_q    <= '0;
      busw_q      <= '0;
      gid_q       <= '0;
      ptr_q       <= '0;
    end else begin
      slot_full_q <= slot_full_d;
      slot_rw_q   <= slot_rw_d;
      slot_data_q <= slot_data_d;
      we_q        <= we_d;
      rw_out_q    <= rw_out_d;
      busw_q      <= busw_d;
      gid_q       <= gid_d;
      ptr_q       <= ptr_d;
    end
  end

  // Pending mask is built from registered state only, so decode sees no
  // combinational path from the requesters.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (slot_full_q[i]) pend_mask = pend_mask | reg_onehot(slot_rw_q[i]);
    end
    if (we_q) pend_mask = pend_mask | reg_onehot(rw_out_q);
  end

  assign WE       = we_q;
  assign Rw       = rw_out_q;
  assign busW     = busw_q;
  assign grant_id = gid_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic              CLK = 1'b0;
  logic              RST_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_rw = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic              WE;
  logic [AW-1:0]     Rw;
  logic [DW-1:0]     busW;
  logic [31:0]       pend_mask;
  logic [2:0]        grant_id;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.N(N), .DW(DW), .AW(AW), .DROP_R0(1'b1)) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_data  (req_data),
    .WE        (WE),
    .Rw        (Rw),
    .busW      (busW),
    .pend_mask (pend_mask),
    .grant_id  (grant_id)
  );

  always #5 CLK = ~CLK;

  // Downstream register file: commits on the falling edge.
  logic [31:0] rf [32];
  always @(negedge CLK) if (WE) rf[Rw] <= busW;

  // ---------------- behavioural reference model ----------------
  bit          m_full [N];
  logic [4:0]  m_rw   [N];
  logic [31:0] m_data [N];
  int          m_ptr;
  bit          m_we;
  logic [4:0]  m_Rw;
  logic [31:0] m_busW;
  int          m_gid;
  int          m_win;
  logic [N-1:0] exp_ready;
  logic [31:0]  exp_pend;
  logic [31:0]  exp_rf [32];

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 0; m_rw[i] = '0; m_data[i] = '0;
    end
    m_ptr = 0; m_we = 0; m_Rw = '0; m_busW = '0; m_gid = 0;
  endfunction

  // Winner = first full slot at or after the pointer; ready/pending from spec rules.
  function automatic void model_comb();
    m_win = -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (m_win < 0 && m_full[c]) m_win = c;
    end
    exp_pend = '0;
    for (int i = 0; i < N; i++) begin
      exp_ready[i] = !m_full[i] || (m_win == i);
      if (m_full[i]) exp_pend[m_rw[i]] = 1'b1;
    end
    if (m_we) exp_pend[m_Rw] = 1'b1;
  endfunction

  task automatic set_req(input int i, input bit v, input logic [4:0] rw, input logic [31:0] d);
    req_valid[i]         = v;
    req_rw[i*AW +: AW]   = rw;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
  endtask

  // One clock: advance the model at the rising edge, return just after the falling edge.
  task automatic tick();
    model_comb();
    @(posedge CLK);
    if (!RST_n) begin
      model_reset();
    end else begin
      if (m_win >= 0) begin
        m_we = 1; m_Rw = m_rw[m_win]; m_busW = m_data[m_win];
        m_gid = m_win; m_ptr = (m_win + 1) % N; m_full[m_win] = 0;
      end else begin
        m_we = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && exp_ready[i] && req_rw[i*AW +: AW] != 5'd0) begin
          m_full[i] = 1;
          m_rw[i]   = req_rw[i*AW +: AW];
          m_data[i] = req_data[i*DW +: DW];
        end
      end
      if (m_we) exp_rf[m_Rw] = m_busW;
    end
    @(negedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_n = 1'b0;
    clear_reqs();
    @(negedge CLK); #1;
    RST_n = 1'b1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if ({WE, Rw, busW, grant_id} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", {WE, Rw, busW, grant_id});
    end
    RST_n = 1'b1;
    model_reset();
    #1;
    checks++;
    if (pend_mask !== 32'h0 || req_ready !== 3'b111) begin
      errors++; $display("FAIL reset_release: pend=%h ready=%b expected pend=0 ready=111", pend_mask, req_ready);
    end
    // Fill three slots, then reset while the first write is on WE.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(3 + i), $urandom);
    tick();
    clear_reqs();
    model_comb();
    checks++;
    if (pend_mask !== 32'h38) begin
      errors++; $display("FAIL reset_prefill_pend: got %h expected %h", pend_mask, 32'h38);
    end
    @(posedge CLK); #2;
    RST_n = 1'b0;
    #1;
    checks++;
    if (WE !== 1'b0 || pend_mask !== 32'h0 || req_ready !== 3'b111) begin
      errors++; $display("FAIL reset_midop: WE=%b pend=%h ready=%b expected 0/0/111", WE, pend_mask, req_ready);
    end
    model_reset();
    @(negedge CLK); #1;
    RST_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (WE !== 1'b0) begin
        errors++; $display("FAIL reset_no_write: cycle %0d WE=%b expected 0", c, WE);
      end
    end
    checks++;
    if (rf[3] !== 32'h0 || rf[4] !== 32'h0 || rf[5] !== 32'h0) begin
      errors++; $display("FAIL reset_rf_untouched: r3=%h r4=%h r5=%h expected 0", rf[3], rf[4], rf[5]);
    end
  endtask

  task automatic test_single();
    set_req(WB_ALU, 1'b1, 5'd7, 32'hDEADBEEF);
    #1;
    checks++;
    if (pend_mask[7] !== 1'b0) begin
      errors++; $display("FAIL single_pend_before: got %b expected 0", pend_mask[7]);
    end
    tick();
    clear_reqs();
    checks++;
    if (WE !== 1'b0 || pend_mask[7] !== 1'b1 || req_ready[0] !== 1'b1) begin
      errors++; $display("FAIL single_cycle_k: WE=%b pend7=%b ready0=%b expected 0/1/1", WE, pend_mask[7], req_ready[0]);
    end
    tick();
    checks++;
    if ({WE, Rw, busW, grant_id} !== {1'b1, 5'd7, 32'hDEADBEEF, 3'd0}) begin
      errors++; $display("FAIL single_write: WE=%b Rw=%0d busW=%h gid=%0d expected 1/7/deadbeef/0", WE, Rw, busW, grant_id);
    end
    checks++;
    if (pend_mask[7] !== 1'b1 || rf[7] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_commit: pend7=%b r7=%h expected 1/deadbeef", pend_mask[7], rf[7]);
    end
    tick();
    checks++;
    if (WE !== 1'b0 || pend_mask !== 32'h0) begin
      errors++; $display("FAIL single_after: WE=%b pend=%h expected 0/0", WE, pend_mask);
    end
  endtask

  task automatic test_all_three();
    logic [31:0] d [N];
    int order [N];
    order[0] = WB_ALU; order[1] = WB_LD; order[2] = WB_MD;
    do_reset();
    for (int i = 0; i < N; i++) begin
      d[i] = $urandom;
      set_req(i, 1'b1, 5'(1 + i), d[i]);
    end
    tick();
    clear_reqs();
    for (int j = 0; j < N; j++) begin
      tick();
      checks++;
      if ({WE, Rw, busW, grant_id} !== {1'b1, 5'(1 + j), d[j], 3'(order[j])}) begin
        errors++; $display("FAIL all3_order[%0d]: WE=%b Rw=%0d busW=%h gid=%0d expected 1/%0d/%h/%0d",
                           j, WE, Rw, busW, grant_id, 1 + j, d[j], order[j]);
      end
    end
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(4 + i), $urandom);
    tick();
    clear_reqs();
    tick();
    checks++;
    if (WE !== 1'b1 || grant_id !== 3'd0 || Rw !== 5'd4) begin
      errors++; $display("FAIL all3_next_round: WE=%b gid=%0d Rw=%0d expected 1/0/4", WE, grant_id, Rw);
    end
    repeat (3) tick();
  endtask

  task automatic test_saturation();
    int cnt [N];
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'($urandom_range(1, 31)), $urandom);
    tick();
    for (int c = 0; c < 30; c++) begin
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'($urandom_range(1, 31)), $urandom);
      model_comb();
      checks++;
      if (m_win < 0 || req_ready !== exp_ready || req_ready[m_win] !== 1'b1) begin
        errors++; $display("FAIL sat_ready: cycle %0d got %b expected %b", c, req_ready, exp_ready);
      end
      tick();
      checks++;
      if ({WE, Rw, busW, grant_id} !== {1'b1, m_Rw, m_busW, 3'(m_gid)}) begin
        errors++; $display("FAIL sat_write: cycle %0d WE=%b Rw=%0d busW=%h gid=%0d expected 1/%0d/%h/%0d",
                           c, WE, Rw, busW, grant_id, m_Rw, m_busW, m_gid);
      end
      if (WE === 1'b1 && grant_id < 3'(N)) cnt[grant_id]++;
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (cnt[i] != 10) begin
        errors++; $display("FAIL sat_fairness[%0d]: got %0d grants expected 10", i, cnt[i]);
      end
    end
    clear_reqs();
    repeat (4) tick();
  endtask

  task automatic test_drop_r0();
    set_req(WB_ALU, 1'b1, 5'd0, 32'h1234);
    #1;
    checks++;
    if (req_ready[0] !== 1'b1) begin
      errors++; $display("FAIL drop_ready_before: got %b expected 1", req_ready[0]);
    end
    tick();
    clear_reqs();
    checks++;
    if (WE !== 1'b0 || req_ready[0] !== 1'b1 || pend_mask[0] !== 1'b0) begin
      errors++; $display("FAIL drop_after_accept: WE=%b ready0=%b pend0=%b expected 0/1/0", WE, req_ready[0], pend_mask[0]);
    end
    tick();
    checks++;
    if (WE !== 1'b0 || rf[0] !== 32'h0) begin
      errors++; $display("FAIL drop_no_write: WE=%b r0=%h expected 0/0", WE, rf[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic [31:0] seen [$];
    int phase, n;
    bit acc;
    a = $urandom; b = ~a; phase = 0; n = 0;
    while (phase < 2 && n < 40) begin
      set_req(WB_ALU, 1'b1, 5'($urandom_range(10, 31)), $urandom);
      set_req(WB_LD, 1'b1, 5'd9, (phase == 0) ? a : b);
      model_comb();
      acc = exp_ready[1];
      tick();
      checks++;
      if ({WE, Rw, busW, grant_id} !== {m_we, m_Rw, m_busW, 3'(m_gid)}) begin
        errors++; $display("FAIL b2b_output: got %h expected %h", {WE, Rw, busW, grant_id}, {m_we, m_Rw, m_busW, 3'(m_gid)});
      end
      if (WE === 1'b1 && Rw === 5'd9) seen.push_back(busW);
      if (acc) phase++;
      n++;
    end
    checks++;
    if (phase < 2) begin
      errors++; $display("FAIL b2b_accept_timeout: accepted %0d expected 2", phase);
    end
    clear_reqs();
    repeat (4) begin
      tick();
      if (WE === 1'b1 && Rw === 5'd9) seen.push_back(busW);
    end
    checks++;
    if (seen.size() != 2) begin
      errors++; $display("FAIL b2b_count: got %0d writes to r9 expected 2", seen.size());
    end else if (seen[0] !== a || seen[1] !== b) begin
      errors++; $display("FAIL b2b_order: got %h,%h expected %h,%h", seen[0], seen[1], a, b);
    end
    checks++;
    if (rf[9] !== b) begin
      errors++; $display("FAIL b2b_final: r9=%h expected %h", rf[9], b);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      model_comb();
      checks++;
      if (req_ready !== exp_ready || pend_mask !== exp_pend) begin
        errors++; $display("FAIL rand_comb: cycle %0d ready=%b pend=%h expected %b/%h", c, req_ready, pend_mask, exp_ready, exp_pend);
      end
      tick();
      checks++;
      if ({WE, Rw, busW, grant_id} !== {m_we, m_Rw, m_busW, 3'(m_gid)}) begin
        errors++; $display("FAIL rand_output: cycle %0d got %h expected %h", c, {WE, Rw, busW, grant_id}, {m_we, m_Rw, m_busW, 3'(m_gid)});
      end
    end
    clear_reqs();
    repeat (5) tick();
    for (int r = 0; r < 32; r++) begin
      checks++;
      if (rf[r] !== exp_rf[r]) begin
        errors++; $display("FAIL rand_rf[%0d]: got %h expected %h", r, rf[r], exp_rf[r]);
      end
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      rf[r] = '0; exp_rf[r] = '0;
    end
    model_reset();
    test_reset();
    test_single();
    test_all_three();
    test_saturation();
    test_drop_r0();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 general-purpose register file between N writeback sources (default 3: ALU, load unit, multiply/divide unit).
- Each source has a valid/ready handshake and a one-entry holding slot. A round-robin arbiter drains one slot per cycle into registered WE/Rw/busW, which drive the register file's write port directly.
- A pending-write mask is exported so the decode stage can stall on RAW hazards against writes not yet committed.

Parameters:
- N, 3, number of writeback requesters (2..8)
- DW, 32, data width of busW
- AW, 5, register address width (32 registers)
- DROP_R0, 1, when 1, requests with rw==0 are accepted and discarded without using the write port

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST_n  input  1  asynchronous active-low reset
- req_valid  input  N  per-requester write request
- req_ready  output  N  per-requester slot can accept this cycle
- req_rw  input  N*AW  per-requester destination register; requester i uses bits [i*AW +: AW]
- req_data  input  N*DW  per-requester write data; requester i uses bits [i*DW +: DW]
- WE  output  1  register-file write enable (registered)
- Rw  output  AW  register-file write address (registered)
- busW  output  DW  register-file write data (registered)
- pend_mask  output  32  bit r = a write to register r is held in a slot or on the output stage
- grant_id  output  3  index of the requester whose write is on WE/Rw/busW (registered)

Behaviour:
- Reset (RST_n low, asynchronous):
  - all slots empty; WE=0, Rw=0, busW=0, grant_id=0; round-robin pointer ptr=0.
  - pend_mask=0 and req_ready all 1 once reset is released.
  - In-flight writes are lost; no partial write may be emitted on release.
- Slot i:
  - Holds full_i, rw_i, data_i.
  - req_ready[i] = !full_i | gnt[i], where gnt is this cycle's combinational grant.
  - Capture at a rising edge when req_valid[i] & req_ready[i].
  - Capture and drain of the same slot in one cycle is allowed; the slot stays full with the new entry.
- DROP_R0=1 and captured rw==0: the slot is not marked full. req_ready stays high, the request is consumed, and it never reaches WE.
- Arbitration (combinational, each cycle):
  - Among full slots, the winner is the first index at or after ptr, wrapping modulo N.
  - No full slot means no grant.
- Output stage (rising edge):
  - With a grant: WE<=1, Rw<=rw_w, busW<=data_w, grant_id<=w, the winner's slot clears (unless refilled the same edge), ptr<=(w+1) mod N.
  - With no grant: WE<=0; Rw, busW and grant_id hold; ptr holds.
- Latency:
  - A request accepted at edge k wins no earlier than cycle k and drives WE from edge k+1 for exactly one cycle.
  - The register file commits at the falling edge inside cycle k+1, so busA/busB reflect the write from that falling edge.
- Throughput: 1 write/cycle aggregate. Under sustained load each of the N requesters is guaranteed one write per N cycles.
- pend_mask = OR over full slots of onehot(rw_i), OR (WE ? onehot(Rw) : 0). It is driven combinationally from registers only; there is no path from req_* inputs.
- Ordering:
  - Writes from one requester are committed in acceptance order (single slot).
  - No ordering is guaranteed between different requesters targeting the same register. Issue logic must hold a producer while the destination bit in pend_mask is set.
- Simultaneous valid on all N with empty slots: all accepted in the same cycle and drained in round-robin order over N cycles.

Decomposition:
- Shared package/header:
  - AW, DW, NREGS=32 constants
  - requester index constants (WB_ALU=0, WB_LD=1, WB_MD=2)
- One natural sub-module: rr_arbiter (N-bit request, pointer in, one-hot grant plus encoded index out). It is reused later for the memory-port arbiter.
- The slot array, output register and pend_mask logic stay in the top.

Test Plan:
- Reset mid-operation: fill slots 0..2 (rw=3,4,5), assert RST_n=0 between edges -> WE=0 immediately, pend_mask=0, no write to r3..r5 after release.
- Single request: req_valid[0] with rw=7, data=0xDEADBEEF at edge k -> WE=1, Rw=7, busW=0xDEADBEEF during cycle k+1 only; r7 reads 0xDEADBEEF after that cycle's falling edge; pend_mask[7] high during cycles k and k+1.
- All three valid in the same cycle (rw=1,2,3) with ptr=0 -> writes appear on consecutive cycles in order 1,2,3 with grant_id 0,1,2; the next contention round starts at requester 0 again.
- Sustained saturation from all requesters for 30 cycles -> each requester gets exactly 10 grants, no gap cycles on WE, and req_ready[i] high in the cycle its slot is granted.
- DROP_R0: req rw=0, data=0x1234 -> WE stays 0, req_ready stays 1, r0 unchanged, pend_mask[0]=0.
- Back-to-back from requester 1 (rw=9 then rw=9, data A then B) while requester 0 is also busy -> r9 final value B; A is committed strictly before B.
